maxpool1_stream: RTL and testbench
==================================

# maxpool1_stream

Streaming 2x2/stride-2 max-pool stage between the conv1 output and the conv2 line buffer. It consumes one channel's 24x24 raster-order pixel stream and emits the pooled 12x12 map in raster order, one pixel per `out_valid` beat. The output directly feeds the conv2 line buffer's `in_valid`/`data_in`. The top level instantiates one copy per channel.

## Interface
- `DATA_BITS`, default 8: pixel width, two's-complement signed on input.
- `IN_WIDTH`, default 24: input frame width and height. Must be even. Output is `IN_WIDTH/2` square.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `data_in` carries the next raster pixel this cycle.
- `data_in`  in  DATA_BITS  conv1 pixel, signed.
- `out_valid`  out  1  one-cycle pulse; `data_out` holds a pooled pixel.
- `data_out`  out  DATA_BITS  pooled pixel.
- `frame_done`  out  1  pulses together with the last pooled pixel of a frame, at output (11,11).

## Operation
- Internal counters:
  - `col_cnt` and `row_cnt` count 0..IN_WIDTH-1.
  - They advance only on `in_valid`.
  - `col_cnt` wraps to 0 at IN_WIDTH-1 and `row_cnt` increments.
  - After pixel (23,23), both wrap to 0. The next frame follows with no idle cycles required.
- `hold_reg` (DATA_BITS): on an even column, the accepted pixel is stored.
- Row buffer `rb[0..IN_WIDTH/2-1]` holds horizontal pair maxima. It is not reset; every entry is written on an even row before it is read on the following odd row.
- Even row, odd column: `rb[col_cnt>>1] <= max(hold_reg, data_in)`.
- Odd row, odd column: `data_out <= max(hold_reg, data_in, rb[col_cnt>>1])`, and `out_valid <= 1`.
- All comparisons are signed, full DATA_BITS. No width growth and no rounding.
- Ties are irrelevant because the value is identical.
- `frame_done` is asserted on the same edge as `out_valid` when `row_cnt==IN_WIDTH-1` and `col_cnt==IN_WIDTH-1`.
- Idle cycles (`in_valid=0`) hold all counters, `hold_reg`, `rb` and `data_out`. `out_valid` and `frame_done` go to 0. Gaps of any length or position (including mid-pair) are legal.
- There is no backpressure. The downstream stage must accept every `out_valid` pulse.

## Timing
- Reset values: `out_valid=0`, `frame_done=0`, `data_out=0`, `col_cnt=0`, `row_cnt=0`, `hold_reg=0`.
- Reset asserted mid-frame aborts the frame. The first `in_valid` beat after release is pixel (0,0). No output from the aborted frame appears afterwards.
- Latency: `out_valid` rises on the clock edge that samples input pixel (2i+1, 2j+1), so it is visible the cycle after that beat.
- Throughput:
  - With continuous input, pulses occur every 2nd cycle during odd input rows and never during even rows.
  - Output pulses are never back-to-back.
  - There are IN_WIDTH²/4 = 144 pulses per frame.
- Output order is raster: (0,0),(0,1)…(0,11),(1,0)…(11,11).
- `data_out` is stable between pulses and holds the last pooled value.

## Configuration
- `MAXPOOL1_RELU_EN` defined:
  - Each accepted `data_in` is clamped to 0 if its MSB is 1, before storage and comparison.
  - `data_out` is therefore always ≥ 0 with MSB 0, which makes it safe for the unsigned conv2 path.
  - This adds no latency.
- Undefined: pure signed max-pool. Negative results pass through unchanged.

## Test plan
- **Ramp frame.** Continuous `in_valid`, pixel(r,c)=r+c. Required: 144 pulses; output (i,j)=2i+2j+2; first pulse the cycle after input beat (1,1); `frame_done` only with output (11,11)=46.
- **Single peak per block.** Every pixel = -5, except pixel (2i+1-(j&1), 2j+(i&1)) = -1.
  - Without the macro: all outputs = 0xFF.
  - With `MAXPOOL1_RELU_EN`: all outputs = 0x00.
- **Random gaps.** Ramp stimulus with `in_valid` randomly low 50% of cycles, including between pair members. Required: output values and order identical to the ramp test; `data_out` unchanged during gaps.
- **Reset mid-frame.** Pulse `rst_n` low after 300 beats, then send a full ramp frame. Required: `out_valid=0` and `data_out=0` during reset; afterwards exactly 144 correct ramp outputs.
- **Back-to-back frames.** Two ramp frames with no idle cycles, then a constant 0x7F frame. Required: 2×144 ramp outputs, then 144 outputs of 0x7F; three `frame_done` pulses, with no stale `rb` data leaking into frame 3.

Source files
------------

// File: rtl/maxpool1_stream.sv
// Streaming 2x2/stride-2 signed max-pool over one channel's IN_WIDTH x IN_WIDTH raster frame.
// Optional build macro MAXPOOL1_RELU_EN clamps negative input pixels to zero before pooling.
module maxpool1_stream #(
    parameter int DATA_BITS = 8,
    parameter int IN_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done
);

    localparam int CW = $clog2(IN_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

    logic [CW-1:0]        col_cnt;
    logic [CW-1:0]        row_cnt;
    logic [DATA_BITS-1:0] hold_reg;
    logic [DATA_BITS-1:0] rb [IN_WIDTH/2];

    logic [DATA_BITS-1:0] pix;
    logic [DATA_BITS-1:0] pair_max;
    logic [DATA_BITS-1:0] block_max;
    logic [CW-2:0]        rb_idx;

    function automatic logic [DATA_BITS-1:0] smax(input logic [DATA_BITS-1:0] a,
                                                  input logic [DATA_BITS-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

`ifdef MAXPOOL1_RELU_EN
    assign pix = data_in[DATA_BITS-1] ? '0 : data_in;
`else
    assign pix = data_in;
`endif

    assign rb_idx    = col_cnt[CW-1:1];
    assign pair_max  = smax(hold_reg, pix);
    assign block_max = smax(pair_max, rb[rb_idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            hold_reg   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (!col_cnt[0]) begin
                    hold_reg <= pix;
                end else if (row_cnt[0]) begin
                    data_out   <= block_max;
                    out_valid  <= 1'b1;
                    frame_done <= (row_cnt == LAST) && (col_cnt == LAST);
                end
                if (col_cnt == LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    // Row buffer is never reset: each entry is rewritten on the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (in_valid && col_cnt[0] && !row_cnt[0]) begin
            rb[rb_idx] <= pair_max;
        end
    end

endmodule

// File: tb/tb_maxpool1_stream.sv
// Directed/randomized bench for maxpool1_stream with a frame-level 2x2 max reference.
module tb_maxpool1_stream;

    localparam int DB = 8;
    localparam int W  = 24;
    localparam int OW = W / 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DB-1:0] data_in;
    logic          out_valid;
    logic [DB-1:0] data_out;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] img [W][W];
    logic [DB-1:0] last_out;
    int            npulse;
    int            nfd;

    maxpool1_stream #(.DATA_BITS(DB), .IN_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sval(input logic [DB-1:0] v);
        int s;
        s = int'($signed(v));
`ifdef MAXPOOL1_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // Reference: fill img for the frame, then push each 2x2 block maximum in raster order.
    task automatic build_frame(input int mode);
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0:       img[r][c] = DB'(r + c);
                    1:       img[r][c] = DB'(-5);
                    2:       img[r][c] = 8'h7F;
                    default: img[r][c] = DB'($urandom_range(255));
                endcase
        if (mode == 1)
            for (int i = 0; i < OW; i++)
                for (int j = 0; j < OW; j++)
                    img[2*i+1-(j%2)][2*j+(i%2)] = DB'(-1);
        for (int i = 0; i < OW; i++)
            for (int j = 0; j < OW; j++) begin
                int m;
                m = sval(img[2*i][2*j]);
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (sval(img[2*i+dr][2*j+dc]) > m) m = sval(img[2*i+dr][2*j+dc]);
                exp_q.push_back(DB'(m));
            end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_out_valid", {31'b0, out_valid}, 0);
        chk("idle_frame_done", {31'b0, frame_done}, 0);
        chk("idle_data_hold", {24'b0, data_out}, {24'b0, last_out});
    endtask

    task automatic beat(input int r, input int c);
        logic          is_out;
        logic [DB-1:0] e;
        in_valid = 1'b1;
        data_in  = img[r][c];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        is_out = (r % 2 == 1) && (c % 2 == 1);
        chk("out_valid", {31'b0, out_valid}, {31'b0, is_out});
        if (is_out) begin
            chk("exp_q_nonempty", {31'b0, exp_q.size() != 0}, 1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            chk("data_out", {24'b0, data_out}, {24'b0, e});
            chk("frame_done", {31'b0, frame_done}, {31'b0, (r == W-1) && (c == W-1)});
            last_out = e;
            npulse++;
            if (frame_done) nfd++;
        end else begin
            chk("data_hold", {24'b0, data_out}, {24'b0, last_out});
            chk("frame_done_low", {31'b0, frame_done}, 0);
        end
    endtask

    task automatic run_frame(input int mode, input int gap_pct, input int max_beats);
        int beats;
        build_frame(mode);
        npulse = 0;
        nfd    = 0;
        beats  = 0;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                if (beats < max_beats) begin
                    for (int g = 0; g < 4; g++)
                        if ($urandom_range(99) < gap_pct) idle_cycle();
                    beat(r, c);
                    beats++;
                end
        if (max_beats >= W*W) begin
            chk("pulse_count", npulse, OW*OW);
            chk("frame_done_count", nfd, 1);
            chk("exp_q_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        last_out = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_frame_done", {31'b0, frame_done}, 0);
        chk("rst_data_out", {24'b0, data_out}, 0);
        rst_n = 1'b1;
        idle_cycle();

        // Ramp frame, continuous input.
        run_frame(0, 0, W*W);
        chk("ramp_last_value", {24'b0, last_out}, 46);
        idle_cycle();

        // One peak per block.
        run_frame(1, 0, W*W);
`ifdef MAXPOOL1_RELU_EN
        chk("peak_value", {24'b0, last_out}, 8'h00);
`else
        chk("peak_value", {24'b0, last_out}, 8'hFF);
`endif

        // Ramp with random gaps, including between pair members.
        run_frame(0, 50, W*W);

        // Random pixel values.
        run_frame(3, 20, W*W);

        // Abort mid-frame with reset, then a full ramp frame.
        run_frame(0, 0, 300);
        exp_q.delete();
        rst_n = 1'b0;
        #3;
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_data_out", {24'b0, data_out}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_out_valid_held", {31'b0, out_valid}, 0);
        chk("midrst_data_out_held", {24'b0, data_out}, 0);
        chk("midrst_frame_done", {31'b0, frame_done}, 0);
        rst_n    = 1'b1;
        last_out = '0;
        run_frame(0, 0, W*W);

        // Back-to-back: two ramps then a constant 0x7F frame, no idle cycles.
        run_frame(0, 0, W*W);
        run_frame(0, 0, W*W);
        run_frame(2, 0, W*W);
        chk("const_last_value", {24'b0, last_out}, 8'h7F);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
